// File: rtl/gfx_pkg.sv
// Shared types and defaults for the scan-out line prefetch path.
package gfx_pkg;
    localparam int unsigned ADDR_W_DEF         = 16;
    localparam int unsigned DATA_W_DEF         = 16;
    localparam int unsigned WORDS_PER_LINE_DEF = 160;
    localparam int unsigned DRAW_SLOT_DEF      = 4;
    localparam int unsigned LB_ADDR_W          = 10;
    localparam int unsigned LINE_IDX_W         = 16;
    localparam int unsigned SLOT_W             = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/fb_fetch_arbiter_if.sv
// Timing, drawing-engine, framebuffer and line-buffer signals of the fetch arbiter.
interface fb_fetch_arbiter_if
    import gfx_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) ();
    logic                  line_start;
    logic [LINE_IDX_W-1:0] line_idx;
    logic [ADDR_W-1:0]     fb_base;
    logic                  draw_req;
    logic [ADDR_W-1:0]     draw_addr;
    logic [DATA_W-1:0]     draw_wdata;
    logic                  draw_gnt;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_we;
    logic                  mem_re;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  lb_we;
    logic [LB_ADDR_W-1:0]  lb_addr;
    logic [DATA_W-1:0]     lb_wdata;
    logic                  lb_bank;
    logic                  fetch_busy;
    logic                  fetch_done;
    logic                  underrun;

    modport master (
        input  line_start, line_idx, fb_base, draw_req, draw_addr, draw_wdata, mem_rdata,
        output draw_gnt, mem_addr, mem_wdata, mem_we, mem_re,
        output lb_we, lb_addr, lb_wdata, lb_bank, fetch_busy, fetch_done, underrun
    );

    modport slave (
        output line_start, line_idx, fb_base, draw_req, draw_addr, draw_wdata, mem_rdata,
        input  draw_gnt, mem_addr, mem_wdata, mem_we, mem_re,
        input  lb_we, lb_addr, lb_wdata, lb_bank, fetch_busy, fetch_done, underrun
    );
endinterface

// File: rtl/fb_fetch_arbiter_fetch_addr_gen.sv
// Line base latch, word counter and the delayed word index used as lb_addr.
module fetch_addr_gen
    import gfx_pkg::*;
#(
    parameter int unsigned ADDR_W         = ADDR_W_DEF,
    parameter int unsigned WORDS_PER_LINE = WORDS_PER_LINE_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LINE_IDX_W-1:0] line_idx,
    input  logic [ADDR_W-1:0]     fb_base,
    input  logic                  advance,
    output logic [ADDR_W-1:0]     rd_addr,
    output logic                  last_word,
    output logic [LB_ADDR_W-1:0]  lb_idx
);
    logic [ADDR_W-1:0]    line_addr;
    logic [LB_ADDR_W-1:0] word_cnt;
    logic [ADDR_W-1:0]    line_off;

    // Product truncated to the address width; all sums wrap.
    assign line_off  = ADDR_W'(32'(line_idx) * 32'(WORDS_PER_LINE));
    assign rd_addr   = line_addr + ADDR_W'(word_cnt);
    assign last_word = (word_cnt == LB_ADDR_W'(WORDS_PER_LINE - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_addr <= '0;
            word_cnt  <= '0;
            lb_idx    <= '0;
        end else begin
            if (start) begin
                line_addr <= fb_base + line_off;
                word_cnt  <= '0;
            end else if (advance) begin
                word_cnt  <= word_cnt + LB_ADDR_W'(1);
            end
            if (advance) begin
                lb_idx <= word_cnt;
            end
        end
    end
endmodule

// File: rtl/fb_fetch_arbiter.sv
// Scan-out line prefetch into a ping-pong line buffer, sharing the framebuffer
// port with the drawing engine's writes (one slot in DRAW_SLOT during a fetch).
module fb_fetch_arbiter
    import gfx_pkg::*;
#(
    parameter int unsigned ADDR_W         = ADDR_W_DEF,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned WORDS_PER_LINE = WORDS_PER_LINE_DEF,
    parameter int unsigned DRAW_SLOT      = DRAW_SLOT_DEF
) (
    input logic                pix_clk,
    input logic                rst_pix,
    fb_fetch_arbiter_if.master bus
);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DRAW_SLOT - 1);

    fetch_state_t         state;
    fetch_state_t         state_nxt;
    logic [SLOT_W-1:0]    slot;
    logic                 lb_pend;
    logic                 lb_bank_q;
    logic                 underrun_q;
    logic                 gnt_c;
    logic                 re_c;
    logic                 abort_c;
    logic [ADDR_W-1:0]    rd_addr;
    logic                 last_word;
    logic [LB_ADDR_W-1:0] lb_idx;

    fetch_addr_gen #(
        .ADDR_W         (ADDR_W),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_addr_gen (
        .clk       (pix_clk),
        .rst_n     (rst_pix),
        .start     (bus.line_start),
        .line_idx  (bus.line_idx),
        .fb_base   (bus.fb_base),
        .advance   (re_c),
        .rd_addr   (rd_addr),
        .last_word (last_word),
        .lb_idx    (lb_idx)
    );

    assign abort_c = bus.line_start && (state != IDLE);

    always_ff @(posedge pix_clk) begin
        if (!rst_pix) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A line_start always wins the cycle: no grant, and the fetch (re)starts.
    always_comb begin
        state_nxt = state;
        gnt_c     = 1'b0;
        re_c      = 1'b0;
        case (state)
            IDLE: begin
                gnt_c = bus.draw_req && !bus.line_start;
                if (bus.line_start) state_nxt = FETCH;
            end
            FETCH: begin
                if (slot == SLOT_LAST && bus.draw_req) gnt_c = !bus.line_start;
                else                                   re_c  = 1'b1;
                if (bus.line_start)          state_nxt = FETCH;
                else if (re_c && last_word)  state_nxt = DRAIN;
            end
            DRAIN: begin
                gnt_c     = bus.draw_req && !bus.line_start;
                state_nxt = bus.line_start ? FETCH : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read-return pipeline, draw slot counter, bank toggle and sticky underrun.
    always_ff @(posedge pix_clk) begin
        if (!rst_pix) begin
            slot       <= '0;
            lb_pend    <= 1'b0;
            lb_bank_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            lb_pend <= re_c && !abort_c;
            if (bus.line_start) begin
                slot      <= '0;
                lb_bank_q <= ~lb_bank_q;
            end else if (state == FETCH) begin
                slot <= (slot == SLOT_LAST) ? '0 : slot + SLOT_W'(1);
            end
            if (abort_c) underrun_q <= 1'b1;
        end
    end

    assign bus.draw_gnt   = gnt_c;
    assign bus.mem_we     = gnt_c;
    assign bus.mem_re     = re_c;
    assign bus.mem_addr   = gnt_c ? bus.draw_addr : (re_c ? rd_addr : ADDR_W'(0));
    assign bus.mem_wdata  = gnt_c ? bus.draw_wdata : DATA_W'(0);
    assign bus.lb_we      = lb_pend && !abort_c;
    assign bus.lb_addr    = lb_idx;
    assign bus.lb_wdata   = bus.mem_rdata;
    assign bus.lb_bank    = lb_bank_q;
    assign bus.fetch_busy = (state != IDLE);
    assign bus.fetch_done = (state == DRAIN) && !bus.line_start;
    assign bus.underrun   = underrun_q;
endmodule

// File: tb/tb_fb_fetch_arbiter.sv
// Directed bench for fb_fetch_arbiter with a read/line-buffer scoreboard.
module tb_fb_fetch_arbiter;
    import gfx_pkg::*;

    localparam int unsigned WPL       = 160;
    localparam int unsigned DS        = 4;
    localparam logic [15:0] DRAW_ADDR = 16'h0005;
    localparam logic [15:0] DRAW_DATA = 16'h1234;

    logic pix_clk;
    logic rst_pix;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    logic [15:0] exp_rd_q[$];
    logic [9:0]  exp_lb_q[$];
    logic [15:0] exp_lbd_q[$];

    fb_fetch_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    fb_fetch_arbiter #(
        .ADDR_W         (16),
        .DATA_W         (16),
        .WORDS_PER_LINE (WPL),
        .DRAW_SLOT      (DS)
    ) dut (
        .pix_clk (pix_clk),
        .rst_pix (rst_pix),
        .bus     (bus.master)
    );

    initial begin
        pix_clk = 1'b0;
        forever #5 pix_clk = ~pix_clk;
    end

    // Framebuffer model: data is a fixed function of the address, one cycle late.
    always @(posedge pix_clk) begin
        bus.mem_rdata <= bus.mem_re ? (bus.mem_addr ^ 16'hA5A5) : 16'h0000;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_line(input logic [15:0] idx, input logic [15:0] base);
        logic [15:0] a;
        for (int i = 0; i < int'(WPL); i++) begin
            a = 16'(32'(base) + 32'(idx) * 32'(WPL) + 32'(i));
            exp_rd_q.push_back(a);
            exp_lb_q.push_back(10'(i));
            exp_lbd_q.push_back(a ^ 16'hA5A5);
        end
    endtask

    task automatic clear_q();
        exp_rd_q.delete();
        exp_lb_q.delete();
        exp_lbd_q.delete();
    endtask

    // Called at posedge+1 of the line_start cycle T from IDLE; returns at T+1.
    task automatic start_line(input logic [15:0] idx, input logic [15:0] base);
        bus.line_start = 1'b1;
        bus.line_idx   = idx;
        bus.fb_base    = base;
        push_line(idx, base);
        @(negedge pix_clk);
        chk("ls_gnt", 32'(bus.draw_gnt), 0);
        chk("ls_re", 32'(bus.mem_re), 0);
        @(posedge pix_clk); #1;
        bus.line_start = 1'b0;
    endtask

    // Cycle model of one fetch starting at T+1; done_cyc is the expected DRAIN cycle.
    task automatic run_line(input int done_cyc, input bit with_draw);
        int reads = 0;
        bit drained = 1'b0;
        for (int k = 1; k <= 400 && !drained; k++) begin
            bit slot_draw;
            @(negedge pix_clk);
            if (k == 1) chk("first_lb_we", 32'(bus.lb_we), 0);
            chk("busy", 32'(bus.fetch_busy), 1);
            if (reads == int'(WPL)) begin
                drained = 1'b1;
                chk("done_cycle", 32'(k), 32'(done_cyc));
                chk("fetch_done", 32'(bus.fetch_done), 1);
                chk("drain_lb_we", 32'(bus.lb_we), 1);
                chk("drain_gnt", 32'(bus.draw_gnt), 32'(with_draw));
                chk("drain_re", 32'(bus.mem_re), 0);
            end else begin
                slot_draw = with_draw && (((k - 1) % int'(DS)) == int'(DS) - 1);
                chk("no_done", 32'(bus.fetch_done), 0);
                chk("gnt", 32'(bus.draw_gnt), 32'(slot_draw));
                chk("mem_we", 32'(bus.mem_we), 32'(slot_draw));
                chk("mem_re", 32'(bus.mem_re), 32'(!slot_draw));
                if (slot_draw) begin
                    chk("draw_addr", 32'(bus.mem_addr), 32'(DRAW_ADDR));
                    chk("draw_wdata", 32'(bus.mem_wdata), 32'(DRAW_DATA));
                end else begin
                    reads++;
                end
            end
            @(posedge pix_clk); #1;
        end
        if (!drained) begin
            checks++;
            errors++;
            $error("FAIL drain_timeout observed=no_drain expected=drain_by_%0d", done_cyc);
        end
        chk("rd_q_empty", 32'(exp_rd_q.size()), 0);
        chk("lb_q_empty", 32'(exp_lb_q.size()), 0);
    endtask

    // Scoreboard: every read and line-buffer write must match the next expected entry.
    always @(negedge pix_clk) begin
        if (mon_en && bus.mem_re === 1'b1) begin
            chk("rd_expected", 32'(exp_rd_q.size() != 0), 1);
            if (exp_rd_q.size() != 0) chk("rd_addr", 32'(bus.mem_addr), 32'(exp_rd_q.pop_front()));
        end
        if (mon_en && bus.lb_we === 1'b1) begin
            chk("lb_expected", 32'(exp_lb_q.size() != 0), 1);
            if (exp_lb_q.size() != 0) begin
                chk("lb_addr", 32'(bus.lb_addr), 32'(exp_lb_q.pop_front()));
                chk("lb_wdata", 32'(bus.lb_wdata), 32'(exp_lbd_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_pix        = 1'b0;
        bus.line_start = 1'b0;
        bus.line_idx   = '0;
        bus.fb_base    = '0;
        bus.draw_req   = 1'b0;
        bus.draw_addr  = '0;
        bus.draw_wdata = '0;

        // Reset values
        repeat (3) @(posedge pix_clk);
        @(negedge pix_clk);
        chk("rst_busy", 32'(bus.fetch_busy), 0);
        chk("rst_done", 32'(bus.fetch_done), 0);
        chk("rst_lb_we", 32'(bus.lb_we), 0);
        chk("rst_re", 32'(bus.mem_re), 0);
        chk("rst_we", 32'(bus.mem_we), 0);
        chk("rst_gnt", 32'(bus.draw_gnt), 0);
        chk("rst_addr", 32'(bus.mem_addr), 0);
        chk("rst_wdata", 32'(bus.mem_wdata), 0);
        chk("rst_lb_addr", 32'(bus.lb_addr), 0);
        chk("rst_bank", 32'(bus.lb_bank), 0);
        chk("rst_underrun", 32'(bus.underrun), 0);
        @(posedge pix_clk); #1;
        rst_pix = 1'b1;
        mon_en  = 1'b1;

        // Plain fetch: 0x1140..0x11DF, done at T+161
        start_line(16'd2, 16'h1000);
        run_line(161, 1'b0);
        @(negedge pix_clk);
        chk("l1_bank", 32'(bus.lb_bank), 1);
        chk("l1_idle", 32'(bus.fetch_busy), 0);
        chk("l1_underrun", 32'(bus.underrun), 0);

        // Draw request while idle goes straight through
        @(posedge pix_clk); #1;
        bus.draw_req   = 1'b1;
        bus.draw_addr  = DRAW_ADDR;
        bus.draw_wdata = 16'hBEEF;
        @(negedge pix_clk);
        chk("idle_gnt", 32'(bus.draw_gnt), 1);
        chk("idle_we", 32'(bus.mem_we), 1);
        chk("idle_addr", 32'(bus.mem_addr), 32'(DRAW_ADDR));
        chk("idle_wdata", 32'(bus.mem_wdata), 32'h0000BEEF);
        chk("idle_re", 32'(bus.mem_re), 0);

        // Same fetch with draw_req held: slots 3,7,11..., done at T+214
        @(posedge pix_clk); #1;
        bus.draw_wdata = DRAW_DATA;
        start_line(16'd2, 16'h1000);
        run_line(214, 1'b1);
        @(negedge pix_clk);
        chk("l2_idle_gnt", 32'(bus.draw_gnt), 1);
        chk("l2_bank", 32'(bus.lb_bank), 0);
        @(posedge pix_clk); #1;
        bus.draw_req = 1'b0;

        // Address wrap 0xFFFF -> 0x0000 at word 16
        start_line(16'd0, 16'hFFF0);
        run_line(161, 1'b0);
        @(negedge pix_clk);
        chk("l3_bank", 32'(bus.lb_bank), 1);

        // Restart 50 cycles into a fetch
        @(posedge pix_clk); #1;
        start_line(16'd1, 16'h2000);
        repeat (49) begin
            @(posedge pix_clk); #1;
        end
        bus.line_start = 1'b1;
        bus.line_idx   = 16'd3;
        bus.fb_base    = 16'h0000;
        @(negedge pix_clk);
        chk("ab_lb_we", 32'(bus.lb_we), 0);
        chk("ab_done", 32'(bus.fetch_done), 0);
        chk("ab_pre_underrun", 32'(bus.underrun), 0);
        @(posedge pix_clk); #1;
        bus.line_start = 1'b0;
        clear_q();
        push_line(16'd3, 16'h0000);
        run_line(161, 1'b0);
        @(negedge pix_clk);
        chk("ab_underrun", 32'(bus.underrun), 1);
        chk("ab_bank", 32'(bus.lb_bank), 1);

        // Reset for one cycle mid-fetch
        mon_en = 1'b0;
        clear_q();
        @(posedge pix_clk); #1;
        bus.line_start = 1'b1;
        bus.line_idx   = 16'd4;
        bus.fb_base    = 16'h3000;
        @(posedge pix_clk); #1;
        bus.line_start = 1'b0;
        repeat (10) begin
            @(posedge pix_clk); #1;
        end
        bus.line_start = 1'b1;
        @(posedge pix_clk); #1;
        bus.line_start = 1'b0;
        repeat (20) begin
            @(posedge pix_clk); #1;
        end
        @(negedge pix_clk);
        chk("pre_rst_busy", 32'(bus.fetch_busy), 1);
        chk("pre_rst_bank", 32'(bus.lb_bank), 1);
        chk("pre_rst_underrun", 32'(bus.underrun), 1);
        @(posedge pix_clk); #1;
        rst_pix = 1'b0;
        @(posedge pix_clk); #1;
        rst_pix = 1'b1;
        @(negedge pix_clk);
        chk("mid_rst_busy", 32'(bus.fetch_busy), 0);
        chk("mid_rst_bank", 32'(bus.lb_bank), 0);
        chk("mid_rst_underrun", 32'(bus.underrun), 0);
        chk("mid_rst_lb_addr", 32'(bus.lb_addr), 0);
        chk("mid_rst_addr", 32'(bus.mem_addr), 0);
        chk("mid_rst_done", 32'(bus.fetch_done), 0);
        for (int i = 0; i < 5; i++) begin
            chk("post_rst_lb_we", 32'(bus.lb_we), 0);
            chk("post_rst_re", 32'(bus.mem_re), 0);
            @(negedge pix_clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fb_fetch_arbiter.md
# fb_fetch_arbiter

Scan-out line prefetch controller and framebuffer arbiter. On each line-start strobe from the display timing path it reads one display line of words from the single-port framebuffer memory into a ping-pong line buffer. It shares that memory with the drawing engine's write port, with bounded starvation for the drawing engine. It sits between the pixel-clock timing generator, the framebuffer RAM and the line buffer, all in the pix_clk domain.

## Interface
- ADDR_W, 16, framebuffer word address width
- DATA_W, 16, framebuffer word width
- WORDS_PER_LINE, 160, words fetched per display line (640 px at 4 bpp); range 2..1024
- DRAW_SLOT, 4, during a fetch, every DRAW_SLOT-th cycle is offered to the drawing engine; range 2..16

Ports:
- pix_clk  in  1  pixel clock; the only clock
- rst_pix  in  1  reset, synchronous, active-low
- line_start  in  1  one-cycle strobe: begin fetching line line_idx
- line_idx  in  16  line to fetch, sampled when line_start=1
- fb_base  in  ADDR_W  framebuffer base address, sampled when line_start=1
- draw_req  in  1  drawing engine write request
- draw_addr  in  ADDR_W  write address
- draw_wdata  in  DATA_W  write data
- draw_gnt  out  1  write accepted this cycle; combinational, requires draw_req
- mem_addr  out  ADDR_W  framebuffer address
- mem_wdata  out  DATA_W  framebuffer write data
- mem_we  out  1  framebuffer write enable; equals draw_gnt
- mem_re  out  1  framebuffer read enable
- mem_rdata  in  DATA_W  read data, valid one cycle after mem_re
- lb_we  out  1  line buffer write enable
- lb_addr  out  10  word index within the line, 0..WORDS_PER_LINE-1
- lb_wdata  out  DATA_W  equals mem_rdata
- lb_bank  out  1  bank being filled; toggles on every accepted line_start
- fetch_busy  out  1  high in FETCH or DRAIN
- fetch_done  out  1  one-cycle pulse with the last lb_we of a line
- underrun  out  1  sticky error flag; cleared only by reset

## Operation
- States: IDLE, FETCH, DRAIN.
- **IDLE**
  - On line_start: latch line_addr = (fb_base + line_idx*WORDS_PER_LINE) mod 2^ADDR_W, clear the word counter and slot counter, toggle lb_bank, go to FETCH.
  - Otherwise draw_gnt = draw_req.
- **FETCH**
  - The slot counter runs 0..DRAW_SLOT-1 and wraps every cycle.
  - When slot counter = DRAW_SLOT-1 and draw_req=1: draw_gnt=1, mem_we=1, with draw address and data. No read that cycle.
  - Every other cycle: mem_re=1, mem_addr = line_addr + word counter, then increment the word counter.
  - After issuing read index WORDS_PER_LINE-1, go to DRAIN.
- **Read return**: one cycle after each mem_re, lb_we=1 and lb_addr = the issued index (a delayed copy of the index).
- **DRAIN**
  - Last read data is written to the line buffer; fetch_done=1; go to IDLE.
  - draw_gnt = draw_req.
- **Address arithmetic**: all address sums are ADDR_W-bit and wrap modulo 2^ADDR_W. The line_idx*WORDS_PER_LINE product is truncated to ADDR_W.
- **line_start while in FETCH or DRAIN**
  - Set underrun.
  - Suppress the lb_we of any in-flight read, and do not pulse fetch_done for the abandoned line.
  - Restart as if in IDLE: relatch, toggle lb_bank, enter FETCH next cycle.
- **Reset mid-fetch**: everything returns to reset values on the next edge; in-flight read data is discarded.

## Timing
- Reset values:
  - State = IDLE.
  - lb_bank = 0, underrun = 0.
  - fetch_busy = 0, fetch_done = 0, lb_we = 0, mem_re = 0, mem_we = 0, draw_gnt = 0.
  - mem_addr, mem_wdata, lb_addr = 0.
- line_start at cycle T: FETCH from T+1, first mem_re at T+1, first lb_we at T+2.
- With no draw_req, last mem_re is at T+WORDS_PER_LINE, and fetch_done with the last lb_we is at T+WORDS_PER_LINE+1.
- Worst-case fetch length with draw_req held high is WORDS_PER_LINE + floor((WORDS_PER_LINE-1)/(DRAW_SLOT-1)) read-issue cycles. The default settings give 213 cycles, well inside an 800-pixel line period.
- A draw request waits at most DRAW_SLOT cycles.

## Structure
- The shared package gfx_pkg holds:
  - the fetch_state_t enum (IDLE, FETCH, DRAIN);
  - the WORDS_PER_LINE and DRAW_SLOT defaults;
  - LB_ADDR_W = 10.
- One sub-module is natural: fetch_addr_gen (line base latch, word counter, delayed index for lb_addr).
- Arbitration and the FSM stay in the top module.

## Test plan
- Reset, then line_start with line_idx=2, fb_base=0x1000, draw_req=0:
  - mem_re on 160 consecutive cycles with addresses 0x1140..0x11DF;
  - lb_we indices 0..159 one cycle later;
  - fetch_done at T+161; lb_bank=1.
- Same fetch with draw_req held high and draw_addr=0x0005:
  - draw_gnt at slot positions 3, 7, 11, …;
  - the read index sequence stays contiguous with no gaps in lb_addr;
  - fetch_done at T+1+213.
- draw_req while IDLE: draw_gnt and mem_we in the same cycle, mem_addr = draw_addr, no mem_re.
- fb_base=0xFFF0, line_idx=0: addresses wrap from 0xFFFF to 0x0000 at word 16.
- Second line_start 50 cycles into a fetch:
  - underrun=1, held through later lines;
  - no lb_we for the in-flight word and no fetch_done for the first line;
  - the new fetch starts at index 0 and lb_bank toggles back.
- rst_pix low for one cycle mid-FETCH: all outputs reach reset values at the next edge and no further lb_we occurs.
